// File: rtl/pcie_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_resp_pkg
// Description : Shared constants and types for the PCIe response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_resp_pkg;

    localparam int PCIE_RESP_DBITS    = 73;
    localparam int PCIE_RESP_LAST_BIT = PCIE_RESP_DBITS - 1;
    localparam int PCIE_RESP_CHNUM    = 2;
    localparam int PCIE_RESP_ABITS    = 2;

    typedef logic [PCIE_RESP_DBITS-1:0] pcie_resp_word_t;

endpackage : pcie_resp_pkg
`default_nettype wire

// File: rtl/pcie_resp_sfifo.sv
`default_nettype none
// ============================================================================
// Module      : pcie_resp_sfifo
// Description : Single-channel synchronous FIFO with head (fall-through) read
//               data, occupancy count and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_resp_sfifo
    import pcie_resp_pkg::*;
#(
    parameter int ABITS = PCIE_RESP_ABITS,
    parameter int DBITS = PCIE_RESP_DBITS
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_wr,
    input  logic [DBITS-1:0] i_wdata,
    output logic             o_full,
    output logic [ABITS:0]   o_cnt,
    output logic             o_ovf,
    input  logic             i_ovf_clr,
    input  logic             i_rd,
    output logic [DBITS-1:0] o_rdata,
    output logic             o_empty
);

    localparam int          DEPTH   = 1 << ABITS;
    localparam logic [ABITS:0] C_DEPTH = (ABITS+1)'(DEPTH);

    logic [DBITS-1:0] mem_q [DEPTH];
    logic [ABITS-1:0] wptr_q;
    logic [ABITS-1:0] rptr_q;
    logic [ABITS:0]   cnt_q;
    logic [ABITS:0]   cnt_d;
    logic             ovf_q;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Full/empty come from the count before any same-cycle pop.
    assign o_full   = (cnt_q == C_DEPTH);
    assign o_empty  = (cnt_q == '0);
    assign w_wr_acc = i_wr && !o_full;
    assign w_rd_acc = i_rd && !o_empty;
    assign o_cnt    = cnt_q;
    assign o_ovf    = ovf_q;
    assign o_rdata  = mem_q[rptr_q];

    // Next occupancy: simultaneous push and pop leave it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            mem_q[wptr_q] <= i_wdata;
        end
    end

    // Pointers, count and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (w_wr_acc) wptr_q <= wptr_q + 1'b1;
            if (w_rd_acc) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
            if (i_wr && o_full) begin
                ovf_q <= 1'b1;
            end else if (i_ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule : pcie_resp_sfifo
`default_nettype wire

// File: rtl/pcie_resp_rr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pcie_resp_rr_fifo
// Description : N-channel response buffer: per-channel FIFOs drained by a
//               round-robin arbiter into one registered, channel-tagged
//               output word (first-word-fall-through).
//               Optional macro PCIE_RESP_PKT_LOCK_EN keeps the grant on one
//               channel until a word with the last flag has been loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_resp_rr_fifo
    import pcie_resp_pkg::*;
#(
    parameter int CHNUM = PCIE_RESP_CHNUM,
    parameter int ABITS = PCIE_RESP_ABITS,
    parameter int DBITS = PCIE_RESP_DBITS,
    parameter int CW    = (CHNUM > 1) ? $clog2(CHNUM) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic [CHNUM-1:0]         i_wr,
    input  logic [CHNUM*DBITS-1:0]   i_wdata,
    output logic [CHNUM-1:0]         o_wfull,
    output logic [CHNUM*(ABITS+1)-1:0] o_wcnt,
    output logic [CHNUM-1:0]         o_ovf,
    input  logic                     i_ovf_clr,
    input  logic                     i_rd,
    output logic [DBITS-1:0]         o_rdata,
    output logic [CW-1:0]            o_rchan,
    output logic                     o_rempty
);

    localparam logic [CW-1:0] C_RR_INIT = CW'(CHNUM - 1);

    logic [CHNUM-1:0] w_empty;
    logic [CHNUM-1:0] w_pop;
    logic [DBITS-1:0] w_head [CHNUM];

    logic             w_load_en;
    logic             w_found;
    logic [CW-1:0]    w_sel;
    int               w_idx;

    logic [DBITS-1:0] rdata_q, rdata_d;
    logic [CW-1:0]    rchan_q, rchan_d;
    logic             rempty_q, rempty_d;
    logic [CW-1:0]    rr_q, rr_d;

    generate
        for (genvar k = 0; k < CHNUM; k++) begin : g_chan
            pcie_resp_sfifo #(
                .ABITS (ABITS),
                .DBITS (DBITS)
            ) u_fifo (
                .i_clk     (i_clk),
                .i_nrst    (i_nrst),
                .i_wr      (i_wr[k]),
                .i_wdata   (i_wdata[k*DBITS +: DBITS]),
                .o_full    (o_wfull[k]),
                .o_cnt     (o_wcnt[k*(ABITS+1) +: (ABITS+1)]),
                .o_ovf     (o_ovf[k]),
                .i_ovf_clr (i_ovf_clr),
                .i_rd      (w_pop[k]),
                .o_rdata   (w_head[k]),
                .o_empty   (w_empty[k])
            );
            assign w_pop[k] = w_load_en && w_found && (w_sel == CW'(k));
        end
    endgenerate

    // The output register may take a word when empty or being popped now.
    assign w_load_en = rempty_q || i_rd;

`ifdef PCIE_RESP_PKT_LOCK_EN
    logic          lock_q, lock_d;
    logic [CW-1:0] lock_ch_q, lock_ch_d;
`endif

    // Grant: first non-empty channel after the last granted one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
`ifdef PCIE_RESP_PKT_LOCK_EN
        if (lock_q) begin
            w_sel   = lock_ch_q;
            w_found = !w_empty[lock_ch_q];
        end else
`endif
        begin
            for (int i = 1; i <= CHNUM; i++) begin
                w_idx = (int'(rr_q) + i) % CHNUM;
                if (!w_found && !w_empty[w_idx]) begin
                    w_found = 1'b1;
                    w_sel   = CW'(w_idx);
                end
            end
        end
    end

    // Output register next state: load granted head, or go empty on a pop.
    always_comb begin
        rdata_d  = rdata_q;
        rchan_d  = rchan_q;
        rempty_d = rempty_q;
        rr_d     = rr_q;
`ifdef PCIE_RESP_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
`endif
        if (w_load_en) begin
            if (w_found) begin
                rdata_d  = w_head[w_sel];
                rchan_d  = w_sel;
                rempty_d = 1'b0;
                rr_d     = w_sel;
`ifdef PCIE_RESP_PKT_LOCK_EN
                lock_d    = !w_head[w_sel][DBITS-1];
                lock_ch_d = w_sel;
`endif
            end else begin
                rempty_d = 1'b1;
            end
        end
    end

    // Output register, round-robin pointer and packet lock state.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rdata_q  <= '0;
            rchan_q  <= '0;
            rempty_q <= 1'b1;
            rr_q     <= C_RR_INIT;
`ifdef PCIE_RESP_PKT_LOCK_EN
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
`endif
        end else begin
            rdata_q  <= rdata_d;
            rchan_q  <= rchan_d;
            rempty_q <= rempty_d;
            rr_q     <= rr_d;
`ifdef PCIE_RESP_PKT_LOCK_EN
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
`endif
        end
    end

    assign o_rdata  = rdata_q;
    assign o_rchan  = rchan_q;
    assign o_rempty = rempty_q;

endmodule : pcie_resp_rr_fifo
`default_nettype wire
